// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter feeding one fifo_uart write port from N_CH byte sources.
// Optional header byte per grant when UART_ARB_HEADER_EN is defined.
module uart_tx_arbiter #(
   parameter int N_CH    = 4,
   parameter int WIDTH   = 8,
   parameter int MAX_LEN = 16
) (
   input  logic                    clk,
   input  logic                    i_reset,
   input  logic                    i_enable,
   input  logic [N_CH-1:0]         i_valid,
   input  logic [N_CH*WIDTH-1:0]   i_data,
   input  logic [N_CH-1:0]         i_last,
   output logic [N_CH-1:0]         o_ready,
   output logic [N_CH-1:0]         o_grant,
   output logic                    o_busy,
   output logic                    o_trunc,
   output logic                    o_w_en,
   output logic [WIDTH-1:0]        o_w_data,
   input  logic                    i_full
);

   localparam int IW = $clog2(N_CH);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_XFER = 2'd2;
`ifdef UART_ARB_HEADER_EN
   localparam logic [1:0] S_HDR  = 2'd1;
`endif
   localparam logic [7:0]    CAP      = 8'(MAX_LEN - 1);
   localparam logic [IW:0]   NCH_L    = (IW + 1)'(N_CH);
   localparam logic [IW-1:0] LAST_IDX = IW'(N_CH - 1);

   logic [1:0]      state_q, state_d;
   logic [N_CH-1:0] grant_q, grant_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [IW-1:0]   rr_q, rr_d;
   logic [7:0]      cnt_q, cnt_d;
   logic            trunc_q, trunc_d;

   logic [WIDTH-1:0] sel_data;
   logic             sel_valid;
   logic             sel_last;

   logic [2*N_CH-1:0] rot_valid;
   logic              pick_found;
   logic [IW:0]       pick_off;
   logic [IW:0]       pick_sum;
   logic [IW-1:0]     pick_idx;

`ifdef UART_ARB_HEADER_EN
   logic [WIDTH-1:0] hdr_byte;

   always_comb begin
      hdr_byte           = '0;
      hdr_byte[WIDTH-1]  = 1'b1;
      hdr_byte[IW-1:0]   = idx_q;
   end
`endif

   // Mux of the currently granted source
   always_comb begin
      sel_data  = '0;
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      for (int k = 0; k < N_CH; k++) begin
         if (idx_q == IW'(k)) begin
            sel_data  = i_data[k*WIDTH +: WIDTH];
            sel_valid = i_valid[k];
            sel_last  = i_last[k];
         end
      end
   end

   // Rotate the request vector so bit 0 is the rr pointer, then take the first set bit
   always_comb begin
      rot_valid  = {i_valid, i_valid} >> rr_q;
      pick_found = 1'b0;
      pick_off   = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (!pick_found && rot_valid[i]) begin
            pick_found = 1'b1;
            pick_off   = (IW + 1)'(i);
         end
      end
      pick_sum = {1'b0, rr_q} + pick_off;
      pick_idx = (pick_sum >= NCH_L) ? IW'(pick_sum - NCH_L) : IW'(pick_sum);
   end

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      idx_d    = idx_q;
      rr_d     = rr_q;
      cnt_d    = cnt_q;
      trunc_d  = 1'b0;
      o_ready  = '0;
      o_w_en   = 1'b0;
      o_w_data = '0;

      case (state_q)
         S_IDLE: begin
            if (i_enable && pick_found) begin
               grant_d = {{(N_CH-1){1'b0}}, 1'b1} << pick_idx;
               idx_d   = pick_idx;
               cnt_d   = '0;
`ifdef UART_ARB_HEADER_EN
               state_d = S_HDR;
`else
               state_d = S_XFER;
`endif
            end
         end
`ifdef UART_ARB_HEADER_EN
         S_HDR: begin
            o_w_data = hdr_byte;
            if (!i_full) begin
               o_w_en  = 1'b1;
               state_d = S_XFER;
            end
         end
`endif
         S_XFER: begin
            o_ready  = grant_q & {N_CH{~i_full}};
            o_w_data = sel_data;
            if (sel_valid && !i_full) begin
               o_w_en = 1'b1;
               cnt_d  = cnt_q + 8'd1;
               // Release on end of packet or when the per-grant byte cap is reached
               if (sel_last || cnt_q == CAP) begin
                  state_d = S_IDLE;
                  grant_d = '0;
                  rr_d    = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                  trunc_d = ~sel_last;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            grant_d = '0;
         end
      endcase

      // A reset cycle must never leak a write or a handshake
      if (i_reset) begin
         o_ready  = '0;
         o_w_en   = 1'b0;
         o_w_data = '0;
      end
   end

   assign o_grant = i_reset ? '0 : grant_q;
   assign o_busy  = ~i_reset & (state_q != S_IDLE);
   assign o_trunc = ~i_reset & trunc_q;

   always_ff @(posedge clk) begin
      if (i_reset) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         idx_q   <= '0;
         rr_q    <= '0;
         cnt_q   <= '0;
         trunc_q <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         idx_q   <= idx_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
         trunc_q <= trunc_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed vector table, multi-cycle sequences and a
// randomized run scored against a packet-level reference model.
module tb_uart_tx_arbiter;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int ML = 16;

   logic           clk = 1'b0;
   logic           i_reset;
   logic           i_enable;
   logic [N-1:0]   i_valid;
   logic [N*W-1:0] i_data;
   logic [N-1:0]   i_last;
   logic [N-1:0]   o_ready;
   logic [N-1:0]   o_grant;
   logic           o_busy;
   logic           o_trunc;
   logic           o_w_en;
   logic [W-1:0]   o_w_data;
   logic           i_full;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.N_CH(N), .WIDTH(W), .MAX_LEN(ML)) dut (
      .clk(clk), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid),
      .i_data(i_data), .i_last(i_last), .o_ready(o_ready), .o_grant(o_grant),
      .o_busy(o_busy), .o_trunc(o_trunc), .o_w_en(o_w_en), .o_w_data(o_w_data),
      .i_full(i_full)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Source streams: {last, data}; the front entry is what the source presents
   logic [8:0] srcq [N][$];

   // Reference model state (packet level)
   bit m_busy, m_hdr, m_trunc;
   int m_owner, m_cnt, m_rr;

   int         glog[$];
   int         seglen[$];
   logic [7:0] wlog[$];
   int         trunc_seen;
   int         cyc;

   int vprob = 100;
   int fprob = 0;
   bit en_ctl = 1'b1;
   bit rnd_en = 1'b0;
   int fs = -1;
   int fe = -1;

   task automatic drive_inputs();
      for (int c = 0; c < N; c++) begin
         if (srcq[c].size() > 0 && int'($urandom_range(99)) < vprob) begin
            i_valid[c]       = 1'b1;
            i_data[c*W +: W] = srcq[c][0][7:0];
            i_last[c]        = srcq[c][0][8];
         end else begin
            i_valid[c]       = 1'b0;
            i_data[c*W +: W] = 8'($urandom);
            i_last[c]        = 1'($urandom);
         end
      end
      i_full   = (cyc >= fs && cyc < fe) || (int'($urandom_range(99)) < fprob);
      i_enable = en_ctl && !(rnd_en && $urandom_range(99) < 5);
   endtask

   task automatic model_step();
      logic [N-1:0] eg, er;
      logic         ew;
      logic [7:0]   ed;
      logic [8:0]   item;
      bit           newt;
      eg = '0; er = '0; ew = 1'b0; ed = '0; newt = 1'b0;
      if (m_busy) begin
         eg = 4'b0001 << m_owner;
         if (m_hdr) begin
            ew = !i_full;
            ed = 8'h80 | 8'(m_owner);
         end else begin
            er = i_full ? 4'b0000 : eg;
            ew = i_valid[m_owner] && !i_full;
            if (srcq[m_owner].size() > 0) ed = srcq[m_owner][0][7:0];
         end
      end
      check("grant", 32'(o_grant), 32'(eg));
      check("ready", 32'(o_ready), 32'(er));
      check("w_en",  32'(o_w_en),  32'(ew));
      check("busy",  32'(o_busy),  32'(m_busy));
      check("trunc", 32'(o_trunc), 32'(m_trunc));
      if (ew && o_w_en) check("w_data", 32'(o_w_data), 32'(ed));
      if (o_w_en) wlog.push_back(o_w_data);
      if (o_trunc) trunc_seen++;

      if (!m_busy) begin
         if (i_enable && |i_valid) begin
            for (int k = 0; k < N; k++) begin
               if (!m_busy && i_valid[(m_rr + k) % N]) begin
                  m_owner = (m_rr + k) % N;
                  m_busy  = 1'b1;
               end
            end
            m_cnt = 0;
`ifdef UART_ARB_HEADER_EN
            m_hdr = 1'b1;
`endif
            glog.push_back(m_owner);
            seglen.push_back(0);
         end
      end else if (m_hdr) begin
         if (!i_full) m_hdr = 1'b0;
      end else if (i_valid[m_owner] && !i_full) begin
         item = srcq[m_owner].pop_front();
         m_cnt++;
         seglen[seglen.size()-1] = seglen[seglen.size()-1] + 1;
         if (item[8] || m_cnt == ML) begin
            m_busy = 1'b0;
            m_rr   = (m_owner + 1) % N;
            newt   = !item[8];
         end
      end
      m_trunc = newt;
   endtask

   task automatic run(input int n);
      repeat (n) begin
         drive_inputs();
         @(negedge clk);
         model_step();
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic do_reset();
      i_reset = 1'b1; i_valid = '0; i_last = '0; i_full = 1'b0; i_enable = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      i_reset = 1'b0;
      m_busy = 0; m_hdr = 0; m_trunc = 0; m_owner = 0; m_cnt = 0; m_rr = 0;
      glog.delete(); seglen.delete(); wlog.delete();
      trunc_seen = 0; cyc = 0; fs = -1; fe = -1;
      vprob = 100; fprob = 0; en_ctl = 1'b1; rnd_en = 1'b0;
      for (int c = 0; c < N; c++) srcq[c].delete();
   endtask

   task automatic push_pkt(input int c, input int len, input int base);
      for (int b = 0; b < len; b++)
         srcq[c].push_back({(b == len - 1) ? 1'b1 : 1'b0, 8'(base + b)});
   endtask

   typedef struct packed {
      logic       rst, en;
      logic [3:0] vld, lst;
      logic       full;
      logic [3:0] g, r;
      logic       wen;
      logic [7:0] wd;
      logic       busy, trunc;
   } vec_t;

   vec_t tbl [15];

   initial begin
`ifndef UART_ARB_HEADER_EN
      tbl[0]  = '{1'b1,1'b1,4'b0100,4'b0100,1'b0, 4'b0000,4'b0000,1'b0,8'h00,1'b0,1'b0};
      tbl[1]  = '{1'b1,1'b1,4'b0100,4'b0100,1'b0, 4'b0000,4'b0000,1'b0,8'h00,1'b0,1'b0};
      tbl[2]  = '{1'b0,1'b1,4'b0101,4'b0101,1'b0, 4'b0000,4'b0000,1'b0,8'h00,1'b0,1'b0};
      tbl[3]  = '{1'b0,1'b1,4'b0101,4'b0101,1'b0, 4'b0001,4'b0001,1'b1,8'hC0,1'b1,1'b0};
      tbl[4]  = '{1'b0,1'b1,4'b0100,4'b0100,1'b0, 4'b0000,4'b0000,1'b0,8'h00,1'b0,1'b0};
      tbl[5]  = '{1'b0,1'b1,4'b0100,4'b0100,1'b0, 4'b0100,4'b0100,1'b1,8'hC2,1'b1,1'b0};
      tbl[6]  = '{1'b0,1'b1,4'b0010,4'b0010,1'b0, 4'b0000,4'b0000,1'b0,8'h00,1'b0,1'b0};
      tbl[7]  = '{1'b0,1'b1,4'b0010,4'b0010,1'b1, 4'b0010,4'b0000,1'b0,8'h00,1'b1,1'b0};
      tbl[8]  = '{1'b0,1'b1,4'b0010,4'b0000,1'b0, 4'b0010,4'b0010,1'b1,8'hC1,1'b1,1'b0};
      tbl[9]  = '{1'b0,1'b1,4'b0000,4'b0000,1'b0, 4'b0010,4'b0010,1'b0,8'h00,1'b1,1'b0};
      tbl[10] = '{1'b0,1'b1,4'b0010,4'b0010,1'b0, 4'b0010,4'b0010,1'b1,8'hC1,1'b1,1'b0};
      tbl[11] = '{1'b0,1'b0,4'b1111,4'b1111,1'b0, 4'b0000,4'b0000,1'b0,8'h00,1'b0,1'b0};
      tbl[12] = '{1'b0,1'b0,4'b1111,4'b1111,1'b0, 4'b0000,4'b0000,1'b0,8'h00,1'b0,1'b0};
      tbl[13] = '{1'b0,1'b1,4'b1000,4'b1000,1'b0, 4'b0000,4'b0000,1'b0,8'h00,1'b0,1'b0};
      tbl[14] = '{1'b0,1'b1,4'b0000,4'b0000,1'b0, 4'b1000,4'b1000,1'b0,8'h00,1'b1,1'b0};

      i_data = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
      for (int i = 0; i < 15; i++) begin
         i_reset = tbl[i].rst; i_enable = tbl[i].en; i_valid = tbl[i].vld;
         i_last = tbl[i].lst; i_full = tbl[i].full;
         @(negedge clk);
         check($sformatf("vec%0d grant", i), 32'(o_grant), 32'(tbl[i].g));
         check($sformatf("vec%0d ready", i), 32'(o_ready), 32'(tbl[i].r));
         check($sformatf("vec%0d w_en",  i), 32'(o_w_en),  32'(tbl[i].wen));
         check($sformatf("vec%0d busy",  i), 32'(o_busy),  32'(tbl[i].busy));
         check($sformatf("vec%0d trunc", i), 32'(o_trunc), 32'(tbl[i].trunc));
         if (tbl[i].wen) check($sformatf("vec%0d w_data", i), 32'(o_w_data), 32'(tbl[i].wd));
         else if (tbl[i].rst) check($sformatf("vec%0d w_data", i), 32'(o_w_data), 32'h0);
         @(posedge clk);
         #1;
      end
`else
      i_data = '0;
      @(posedge clk);
      #1;
`endif

      // Round robin with continuous 3-byte packets on every source
      do_reset();
      for (int c = 0; c < N; c++) begin
         push_pkt(c, 3, c*16);
         push_pkt(c, 3, c*16 + 3);
      end
      run(40);
      check("rr g0", 32'(glog[0]), 32'd0);
      check("rr g1", 32'(glog[1]), 32'd1);
      check("rr g2", 32'(glog[2]), 32'd2);
      check("rr g3", 32'(glog[3]), 32'd3);
      check("rr g4", 32'(glog[4]), 32'd0);
`ifndef UART_ARB_HEADER_EN
      check("rr bytes", 32'(wlog.size()), 32'd24);
      check("rr w3",  32'(wlog[3]),  32'h10);
      check("rr w11", 32'(wlog[11]), 32'h32);
      check("rr w12", 32'(wlog[12]), 32'h03);
`endif

      // MAX_LEN cap on a 20-byte packet
      do_reset();
      push_pkt(1, 20, 8'h40);
      push_pkt(2, 2, 8'h60);
      run(60);
      check("cap g0", 32'(glog[0]), 32'd1);
      check("cap g1", 32'(glog[1]), 32'd2);
      check("cap g2", 32'(glog[2]), 32'd1);
      check("cap len0", 32'(seglen[0]), 32'd16);
      check("cap len1", 32'(seglen[1]), 32'd2);
      check("cap len2", 32'(seglen[2]), 32'd4);
      check("cap trunc pulses", 32'(trunc_seen), 32'd1);
      check("cap drained", 32'(srcq[1].size()), 32'd0);

      // Backpressure held for 5 cycles mid-packet
      do_reset();
      push_pkt(0, 10, 8'h20);
      fs = 4; fe = 9;
      run(30);
      check("bp grants", 32'(glog.size()), 32'd1);
      check("bp len", 32'(seglen[0]), 32'd10);
      check("bp drained", 32'(srcq[0].size()), 32'd0);

      // Enable dropped during byte 2 of a 6-byte packet
      do_reset();
      push_pkt(3, 6, 8'h70);
      run(3);
      en_ctl = 1'b0;
      push_pkt(0, 2, 8'h90);
      run(20);
      check("en grants", 32'(glog.size()), 32'd1);
      check("en len", 32'(seglen[0]), 32'd6);
      check("en held", 32'(srcq[0].size()), 32'd2);
      en_ctl = 1'b1;
      run(10);
      check("en regrant", 32'(glog.size()), 32'd2);
      check("en regrant ch", 32'(glog[1]), 32'd0);

`ifdef UART_ARB_HEADER_EN
      // Header byte with backpressure during HDR
      do_reset();
      srcq[2].push_back(9'h0A1);
      srcq[2].push_back(9'h1A2);
      fs = 1; fe = 4;
      run(12);
      check("hdr count", 32'(wlog.size()), 32'd3);
      check("hdr w0", 32'(wlog[0]), 32'h82);
      check("hdr w1", 32'(wlog[1]), 32'hA1);
      check("hdr w2", 32'(wlog[2]), 32'hA2);
`endif

      // Randomized traffic, gaps, backpressure and enable toggling
      do_reset();
      for (int c = 0; c < N; c++)
         for (int p = 0; p < 5; p++)
            push_pkt(c, int'($urandom_range(1, 24)), int'($urandom_range(0, 255)));
      vprob = 70; fprob = 20; rnd_en = 1'b1;
      run(3000);
      vprob = 100; fprob = 0; rnd_en = 1'b0;
      run(600);
      for (int c = 0; c < N; c++)
         check($sformatf("rand drained ch%0d", c), 32'(srcq[c].size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
